// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl_if
// Brief    : Instruction handshake, ALU operand/result bus and completion
//            status for the issue/write-back controller.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 16
);
  // instruction handshake
  logic             instr_valid;
  logic [15:0]      instr;
  logic             instr_ready;
  // ALU operand bus (controller -> ALU)
  logic [WIDTH-1:0] alu_data1;
  logic [WIDTH-1:0] alu_data2;
  logic [1:0]       alu_op;
  // ALU result bus (ALU -> controller)
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  // completion status
  logic             done;
  logic             zero_flag;

  // environment side: instruction source and the ALU itself
  modport master (
    output instr_valid, instr, alu_result, alu_zero,
    input  instr_ready, alu_data1, alu_data2, alu_op, done, zero_flag
  );

  // controller side
  modport slave (
    input  instr_valid, instr, alu_result, alu_zero,
    output instr_ready, alu_data1, alu_data2, alu_op, done, zero_flag
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Brief    : Multi-cycle issue/write-back controller. Accepts one instruction,
//            reads operands from an 8x16 register file, feeds the external
//            ALU, captures its result and writes it back (IDLE/RD/EX/WB).
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  alu_issue_ctrl_if.slave       bus,
  input  wire logic [2:0]       dbg_addr,
  output logic      [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_EX   = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [15:0]      r_instr;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_alu_data1;
  logic [WIDTH-1:0] r_alu_data2;
  logic [1:0]       r_alu_op;
  logic [WIDTH-1:0] r_res;
  logic             r_res_zero;
  logic             r_zero_flag;

  logic             w_ready;
  logic             w_done;
  logic             w_accept;
  logic             w_load_ops;
  logic             w_capture;
  logic             w_writeback;

  // latched instruction fields
  logic [1:0]       w_op;
  logic [2:0]       w_rd;
  logic [2:0]       w_rs1;
  logic [2:0]       w_rs2;
  logic             w_use_imm;
  logic [3:0]       w_imm4;
  logic [WIDTH-1:0] w_src1;
  logic [WIDTH-1:0] w_src2;

  assign w_op      = r_instr[15:14];
  assign w_rd      = r_instr[13:11];
  assign w_rs1     = r_instr[10:8];
  assign w_rs2     = r_instr[7:5];
  assign w_use_imm = r_instr[4];
  assign w_imm4    = r_instr[3:0];

  // r0 is hard-wired to zero on every read port
  assign w_src1   = (w_rs1 == 3'd0) ? '0 : r_regs[w_rs1];
  assign w_src2   = w_use_imm ? {{(WIDTH-4){1'b0}}, w_imm4}
                  : ((w_rs2 == 3'd0) ? '0 : r_regs[w_rs2]);
  assign dbg_data = (dbg_addr == 3'd0) ? '0 : r_regs[dbg_addr];

  assign bus.instr_ready = w_ready;
  assign bus.done        = w_done;
  assign bus.alu_data1   = r_alu_data1;
  assign bus.alu_data2   = r_alu_data2;
  assign bus.alu_op      = r_alu_op;
  assign bus.zero_flag   = r_zero_flag;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next-state decode and per-state strobes
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_done      = 1'b0;
    w_accept    = 1'b0;
    w_load_ops  = 1'b0;
    w_capture   = 1'b0;
    w_writeback = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.instr_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RD;
        end
      end
      S_RD: begin
        w_load_ops  = 1'b1;
        w_state_nxt = S_EX;
      end
      S_EX: begin
        w_capture   = 1'b1;
        w_state_nxt = S_WB;
      end
      S_WB: begin
        w_done      = 1'b1;
        w_writeback = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // instruction latch; the word is only sampled on an accepted handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_instr <= '0;
    else if (w_accept) r_instr <= bus.instr;
  end

  // ALU operand registers hold their value outside the RD cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_data1 <= '0;
      r_alu_data2 <= '0;
      r_alu_op    <= 2'b00;
    end else if (w_load_ops) begin
      r_alu_data1 <= w_src1;
      r_alu_data2 <= w_src2;
      r_alu_op    <= w_op;
    end
  end

  // capture the ALU result once its inputs have been stable for a cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res      <= '0;
      r_res_zero <= 1'b0;
    end else if (w_capture) begin
      r_res      <= bus.alu_result;
      r_res_zero <= bus.alu_zero;
    end
  end

  // sticky zero flag from the last completed instruction (including rd=0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_zero_flag <= 1'b0;
    else if (w_writeback) r_zero_flag <= r_res_zero;
  end

  // register file write-back; writes to r0 are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_writeback && (w_rd != 3'd0)) begin
      r_regs[w_rd] <= r_res;
    end
  end

endmodule
`default_nettype wire
